// File: rtl/conv_out_drain.sv
// Output-BRAM drain: reads conv results through a 1-cycle BRAM pipeline into a prefetch FIFO
// and streams them out as an AXI-Stream master, one beat per cycle when the sink keeps up.
module conv_out_drain #(
    parameter int unsigned AXI_HP_BIT = 64,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sudo_reset,
    input  logic                  drain_en,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  drain_done,
    output logic                  out_rd_en,
    output logic [ADDR_WIDTH-1:0] out_rd_addr,
    input  logic [AXI_HP_BIT-1:0] out_rd_data,
    output logic [AXI_HP_BIT-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LenW = ADDR_WIDTH + 1;
    localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [LenW-1:0]       count_q, count_d;
    logic [LenW-1:0]       issued_q, issued_d;
    logic [LenW-1:0]       beats_q, beats_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  inflight_q, inflight_d;
    logic                  done_q, done_d;
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       fifo_cnt_q, fifo_cnt_d;
    logic [AXI_HP_BIT-1:0] mem_q [FIFO_DEPTH];

    logic            push, pop, can_issue;
    logic [CntW:0]   occ;
    logic [LenW-1:0] last_idx;

    assign busy        = (state_q != StIdle);
    assign drain_done  = done_q;
    assign out_rd_en   = rd_en_q;
    assign out_rd_addr = rd_addr_q;

    always_comb begin
        m_axis_tvalid = (fifo_cnt_q != '0);
        m_axis_tdata  = mem_q[rd_ptr_q];
        last_idx      = count_q - LenW'(1);
        m_axis_tlast  = m_axis_tvalid && (beats_q == last_idx);
        pop           = m_axis_tvalid && m_axis_tready;
        push          = inflight_q;
        // Credit counts the read on the BRAM port this cycle as well as the one returning,
        // so every outstanding read already owns a FIFO slot.
        occ       = {1'b0, fifo_cnt_q} + {{CntW{1'b0}}, rd_en_q} + {{CntW{1'b0}}, inflight_q};
        can_issue = (issued_q < count_q) && (occ < DepthC);

        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        issued_d   = issued_q;
        beats_d    = beats_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        inflight_d = rd_en_q;
        done_d     = 1'b0;
        wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop) fifo_cnt_d = fifo_cnt_q + CntW'(1);
        if (pop && !push) fifo_cnt_d = fifo_cnt_q - CntW'(1);

        unique case (state_q)
            StIdle: begin
                if (drain_en) begin
                    base_d   = base_addr;
                    count_d  = word_count;
                    issued_d = '0;
                    beats_d  = '0;
                    if (word_count == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d   = StRun;
                        rd_en_d   = 1'b1;
                        rd_addr_d = base_addr;
                        issued_d  = LenW'(1);
                    end
                end
            end
            StRun: begin
                if (can_issue) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + issued_q[ADDR_WIDTH-1:0];
                    issued_d  = issued_q + LenW'(1);
                end
                if (pop) begin
                    beats_d = beats_q + LenW'(1);
                    if (m_axis_tlast) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                // Entered with the pulse already raised, except on a zero-length drain.
                if (done_q) state_d = StIdle;
                else        done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (sudo_reset) begin
            state_d    = StIdle;
            base_d     = '0;
            count_d    = '0;
            issued_d   = '0;
            beats_d    = '0;
            rd_en_d    = 1'b0;
            rd_addr_d  = '0;
            inflight_d = 1'b0;
            done_d     = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            beats_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            beats_q    <= beats_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= out_rd_data;
    end

endmodule

// File: tb/tb_conv_out_drain.sv
// Bench for conv_out_drain: BRAM behavioural model, per-scenario tasks, queue-based beat model.
module tb_conv_out_drain;

    localparam int AW  = 14;
    localparam int DW  = 64;
    localparam int ASZ = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, sudo_reset, drain_en;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_count;
    logic          busy, drain_done, out_rd_en;
    logic [AW-1:0] out_rd_addr;
    logic [DW-1:0] out_rd_data;
    logic [DW-1:0] tdata;
    logic          tvalid, tready, tlast;

    logic [DW-1:0] bram [ASZ];

    int total = 0;
    int bad   = 0;

    int            rd_cyc[$];
    logic [AW-1:0] rd_adr[$];
    int            bt_cyc[$];
    logic [DW-1:0] bt_dat[$];
    logic          bt_last[$];
    int            dn_cyc[$];
    int            first_valid, stall_bad, max_out;
    bit            timed_out;
    logic          sr_valid, sr_busy, sr_rden;

    conv_out_drain #(.AXI_HP_BIT(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sudo_reset   (sudo_reset),
        .drain_en     (drain_en),
        .base_addr    (base_addr),
        .word_count   (word_count),
        .busy         (busy),
        .drain_done   (drain_done),
        .out_rd_en    (out_rd_en),
        .out_rd_addr  (out_rd_addr),
        .out_rd_data  (out_rd_data),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tlast (tlast)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_rd_en) out_rd_data <= bram[out_rd_addr];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_beat(input int b, input int k);
        return bram[(b + k) % ASZ];
    endfunction

    // Runs one drain and records what the DUT did; cycle c is c clocks after the drain_en cycle.
    task automatic do_drain(input int b, input int n, input int mode, input int sudo_at,
                            input int glitch_at);
        int            limit, stop_at;
        bit            sudo_done, sr_pending, prev_st;
        logic [DW-1:0] prev_dat;
        logic          prev_last;
        rd_cyc.delete(); rd_adr.delete(); bt_cyc.delete(); bt_dat.delete();
        bt_last.delete(); dn_cyc.delete();
        first_valid = -1; stall_bad = 0; max_out = 0; timed_out = 1'b0;
        sr_valid = 1'bx; sr_busy = 1'bx; sr_rden = 1'bx;
        limit = n * 10 + 40; stop_at = -1;
        sudo_done = 1'b0; sr_pending = 1'b0; prev_st = 1'b0; prev_dat = '0; prev_last = 1'b0;
        base_addr  = AW'(b);
        word_count = (AW + 1)'(n);
        drain_en   = 1'b1;
        tready     = 1'b0;
        step();
        base_addr  = AW'($urandom);
        word_count = (AW + 1)'($urandom);
        for (int c = 1; c <= limit; c++) begin
            drain_en   = 1'b0;
            sudo_reset = 1'b0;
            if (sr_pending) begin
                sr_valid = tvalid; sr_busy = busy; sr_rden = out_rd_en; sr_pending = 1'b0;
            end
            if (c == glitch_at) begin
                drain_en   = 1'b1;
                base_addr  = AW'($urandom);
                word_count = (AW + 1)'($urandom_range(1, 30));
            end
            case (mode)
                0:       tready = 1'b1;
                1:       tready = ((c % 3) == 0);
                default: tready = 1'($urandom_range(0, 1));
            endcase
            if (sudo_at >= 0 && !sudo_done && bt_cyc.size() == sudo_at) begin
                sudo_reset = 1'b1; tready = 1'b0; sudo_done = 1'b1; sr_pending = 1'b1;
                stop_at = c + 8;
            end
            #0;
            if (out_rd_en) begin
                rd_cyc.push_back(c);
                rd_adr.push_back(out_rd_addr);
            end
            if (rd_cyc.size() - bt_cyc.size() > max_out) max_out = rd_cyc.size() - bt_cyc.size();
            if (prev_st && (!tvalid || tdata !== prev_dat || tlast !== prev_last)) stall_bad++;
            if (tvalid && first_valid < 0) first_valid = c;
            if (tvalid && tready) begin
                bt_cyc.push_back(c);
                bt_dat.push_back(tdata);
                bt_last.push_back(tlast);
            end
            if (drain_done) begin
                dn_cyc.push_back(c);
                if (stop_at < 0) stop_at = c + 3;
            end
            prev_st   = tvalid && !tready && !sudo_reset;
            prev_dat  = tdata;
            prev_last = tlast;
            if (c == stop_at) break;
            step();
        end
        if (stop_at < 0) timed_out = 1'b1;
        tready = 1'b0; sudo_reset = 1'b0; drain_en = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset = 1'b0; sudo_reset = 1'b0; drain_en = 1'b0; tready = 1'b0;
        base_addr = '0; word_count = '0;
        step(); step();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (drain_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", drain_done); end
        total++; if (out_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rden: got %b want 0", out_rd_en); end
        total++; if (out_rd_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", out_rd_addr); end
        total++; if (tvalid !== 1'b0 || tlast !== 1'b0) begin
            bad++; $display("FAIL reset_stream: got valid=%b last=%b want 0 0", tvalid, tlast);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 8; i++) bram[i] = DW'(i);
        do_drain(0, 8, 0, -1, -1);
        total++; if (timed_out || rd_cyc.size() != 8) begin
            bad++; $display("FAIL basic_nreads: got %0d want 8", rd_cyc.size());
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (k >= rd_cyc.size() || rd_cyc[k] != k + 1 || rd_adr[k] !== AW'(k)) begin
                bad++; $display("FAIL basic_read%0d: got cycle/addr mismatch want cycle %0d addr %0d", k, k + 1, k);
            end
            total++;
            if (k >= bt_cyc.size() || bt_cyc[k] != k + 3 || bt_dat[k] !== DW'(k) ||
                bt_last[k] !== (k == 7)) begin
                bad++; $display("FAIL basic_beat%0d: got beat mismatch want cycle %0d data %0d", k, k + 3, k);
            end
        end
        total++; if (bt_cyc.size() != 8) begin bad++; $display("FAIL basic_nbeats: got %0d want 8", bt_cyc.size()); end
        total++; if (first_valid != 3) begin bad++; $display("FAIL basic_first_valid: got %0d want 3", first_valid); end
        total++; if (dn_cyc.size() != 1 || dn_cyc[0] != 11) begin
            bad++; $display("FAIL basic_done: got %0d pulses want 1 at cycle 11", dn_cyc.size());
        end
    endtask

    task automatic test_backpressure();
        int errs = 0;
        do_drain(40, 16, 1, -1, -1);
        for (int k = 0; k < 16; k++)
            if (k >= bt_dat.size() || bt_dat[k] !== exp_beat(40, k) || bt_last[k] !== (k == 15)) errs++;
        total++; if (timed_out || bt_dat.size() != 16) begin
            bad++; $display("FAIL bp_nbeats: got %0d want 16", bt_dat.size());
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_data: got %0d bad beats want 0", errs); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL bp_stable: got %0d changes want 0", stall_bad); end
        total++; if (max_out > 4) begin bad++; $display("FAIL bp_credit: got %0d outstanding want <=4", max_out); end
        total++; if (dn_cyc.size() != 1) begin bad++; $display("FAIL bp_done: got %0d pulses want 1", dn_cyc.size()); end
    endtask

    task automatic test_zero();
        do_drain(7, 0, 0, -1, -1);
        total++; if (dn_cyc.size() != 1 || dn_cyc[0] != 2) begin
            bad++; $display("FAIL zero_done: got %0d pulses want 1 at cycle 2", dn_cyc.size());
        end
        total++; if (rd_cyc.size() != 0) begin bad++; $display("FAIL zero_reads: got %0d want 0", rd_cyc.size()); end
        total++; if (first_valid != -1) begin bad++; $display("FAIL zero_valid: got cycle %0d want none", first_valid); end
    endtask

    task automatic test_wrap();
        int exp_a[4] = '{16382, 16383, 0, 1};
        do_drain(16382, 4, 0, -1, -1);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (k >= rd_adr.size() || rd_adr[k] !== AW'(exp_a[k])) begin
                bad++; $display("FAIL wrap_addr%0d: got mismatch want %0d", k, exp_a[k]);
            end
            total++;
            if (k >= bt_dat.size() || bt_dat[k] !== bram[exp_a[k]] || bt_last[k] !== (k == 3)) begin
                bad++; $display("FAIL wrap_beat%0d: got mismatch want %h", k, bram[exp_a[k]]);
            end
        end
        total++; if (timed_out || bt_dat.size() != 4) begin
            bad++; $display("FAIL wrap_nbeats: got %0d want 4", bt_dat.size());
        end
    endtask

    task automatic test_sudo();
        int late = 0;
        do_drain(500, 10, 0, 3, -1);
        total++; if (bt_dat.size() != 3) begin bad++; $display("FAIL sudo_beats: got %0d want 3", bt_dat.size()); end
        total++; if (sr_valid !== 1'b0 || sr_busy !== 1'b0 || sr_rden !== 1'b0) begin
            bad++; $display("FAIL sudo_clear: got valid=%b busy=%b rden=%b want 0 0 0", sr_valid, sr_busy, sr_rden);
        end
        total++; if (dn_cyc.size() != 0) begin bad++; $display("FAIL sudo_done: got %0d pulses want 0", dn_cyc.size()); end
        foreach (rd_cyc[i]) if (rd_cyc[i] > 6) late++;
        total++; if (late != 0) begin bad++; $display("FAIL sudo_reads: got %0d late reads want 0", late); end
        do_drain(100, 2, 0, -1, -1);
        total++; if (bt_dat.size() != 2 || bt_dat[0] !== bram[100] || bt_dat[1] !== bram[101]) begin
            bad++; $display("FAIL sudo_restart: got %0d beats want BRAM[100],BRAM[101]", bt_dat.size());
        end
        total++; if (dn_cyc.size() != 1) begin bad++; $display("FAIL sudo_restart_done: got %0d want 1", dn_cyc.size()); end
    endtask

    task automatic test_ignored_start();
        int errs = 0;
        do_drain(200, 10, 0, -1, 4);
        for (int k = 0; k < 10; k++)
            if (k >= bt_dat.size() || bt_dat[k] !== exp_beat(200, k)) errs++;
        total++; if (bt_dat.size() != 10 || errs != 0) begin
            bad++; $display("FAIL ignored_data: got %0d beats %0d bad want 10 0", bt_dat.size(), errs);
        end
        total++; if (dn_cyc.size() != 1) begin bad++; $display("FAIL ignored_done: got %0d want 1", dn_cyc.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_idle: got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 6; r++) begin
            int b    = (r % 2) ? $urandom_range(ASZ - 12, ASZ - 1) : $urandom_range(0, ASZ - 1);
            int n    = $urandom_range(1, 24);
            int errs = 0;
            do_drain(b, n, 2, -1, -1);
            for (int k = 0; k < n; k++)
                if (k >= bt_dat.size() || bt_dat[k] !== exp_beat(b, k) || bt_last[k] !== (k == n - 1))
                    errs++;
            total++; if (timed_out || bt_dat.size() != n || errs != 0) begin
                bad++; $display("FAIL rand%0d_data: got %0d beats %0d bad want %0d 0", r, bt_dat.size(), errs, n);
            end
            total++; if (stall_bad != 0 || max_out > 4) begin
                bad++; $display("FAIL rand%0d_flow: got stall=%0d outstanding=%0d want 0 <=4", r, stall_bad, max_out);
            end
            total++; if (dn_cyc.size() != 1) begin bad++; $display("FAIL rand%0d_done: got %0d want 1", r, dn_cyc.size()); end
        end
    endtask

    initial begin
        for (int i = 0; i < ASZ; i++) bram[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_backpressure();
        test_zero();
        test_wrap();
        test_sudo();
        test_ignored_start();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
